// File: rtl/prod3_engine.sv
// prod3_engine: hardwired D = A*B*C responder on the start/done memory port.
// Define PROD3_ENGINE_EARLY_ZERO_EN to skip the multiply when any operand is 0.
module prod3_engine #(
  parameter int            AW        = 8,
  parameter logic [AW-1:0] OPA_ADDR  = '0,
  parameter logic [AW-1:0] PROD_ADDR = AW'(3)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);

  typedef enum logic [3:0] {
    IDLE,
    RD_A,
    RD_B,
    RD_C,
    MUL1,
    MUL2,
    FIX,
    WR0,
    WR1,
    WR2,
    DONE
  } state_t;

  state_t      state;
  logic        start_q;
  logic        wr_q;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic        sgn;
  logic [15:0] mc1;
  logic [7:0]  mp1;
  logic [15:0] acc1;
  logic [23:0] mc2;
  logic [7:0]  mp2;
  logic [23:0] acc2;
  logic [2:0]  cnt;
  logic [23:0] res;

  logic [15:0] acc1_nx;
  logic [23:0] acc2_nx;
  logic [23:0] fix;

  // 8-bit magnitude; -128 maps to unsigned 128
  function automatic logic [7:0] mag(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

  always_comb begin
    acc1_nx = mp1[0] ? (acc1 + mc1) : acc1;
    acc2_nx = mp2[0] ? (acc2 + mc2) : acc2;
    fix     = sgn ? (~res + 24'd1) : res;
  end

  // a write pending when reset arrives must not land
  assign mem_wr_en = wr_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      start_q     <= 1'b1;
      done        <= 1'b0;
      wr_q        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      opa         <= '0;
      opb         <= '0;
      sgn         <= 1'b0;
      mc1         <= '0;
      mp1         <= '0;
      acc1        <= '0;
      mc2         <= '0;
      mp2         <= '0;
      acc2        <= '0;
      cnt         <= '0;
      res         <= '0;
    end else begin
      start_q <= start;
      unique case (state)
        IDLE: begin
          if (start_q && !start) begin
            state    <= RD_A;
            mem_addr <= OPA_ADDR;
          end
        end
        RD_A: begin
          opa      <= mem_rd_data;
          mem_addr <= OPA_ADDR + AW'(1);
          state    <= RD_B;
        end
        RD_B: begin
          opb      <= mem_rd_data;
          mem_addr <= OPA_ADDR + AW'(2);
          state    <= RD_C;
        end
        RD_C: begin
          mc1      <= {8'h00, mag(opa)};
          mp1      <= mag(opb);
          mp2      <= mag(mem_rd_data);
          sgn      <= opa[7] ^ opb[7] ^ mem_rd_data[7];
          acc1     <= '0;
          cnt      <= '0;
          mem_addr <= '0;
`ifdef PROD3_ENGINE_EARLY_ZERO_EN
          if (opa == 8'h00 || opb == 8'h00 ||
              mem_rd_data == 8'h00) begin
            res         <= '0;
            mem_addr    <= PROD_ADDR;
            mem_wr_data <= 8'h00;
            wr_q        <= 1'b1;
            state       <= WR0;
          end else begin
            state <= MUL1;
          end
`else
          state <= MUL1;
`endif
        end
        MUL1: begin
          acc1 <= acc1_nx;
          mc1  <= mc1 << 1;
          mp1  <= mp1 >> 1;
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            mc2   <= {8'h00, acc1_nx};
            acc2  <= '0;
            state <= MUL2;
          end
        end
        MUL2: begin
          acc2 <= acc2_nx;
          mc2  <= mc2 << 1;
          mp2  <= mp2 >> 1;
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            res   <= acc2_nx;
            state <= FIX;
          end
        end
        FIX: begin
          res         <= fix;
          mem_addr    <= PROD_ADDR;
          mem_wr_data <= fix[7:0];
          wr_q        <= 1'b1;
          state       <= WR0;
        end
        WR0: begin
          mem_addr    <= PROD_ADDR + AW'(1);
          mem_wr_data <= res[15:8];
          state       <= WR1;
        end
        WR1: begin
          mem_addr    <= PROD_ADDR + AW'(2);
          mem_wr_data <= res[23:16];
          state       <= WR2;
        end
        WR2: begin
          wr_q        <= 1'b0;
          mem_addr    <= '0;
          mem_wr_data <= '0;
          state       <= DONE;
        end
        DONE: begin
          done <= 1'b1;
          if (done && start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
